// File: rtl/cu_dispatch_receiver.sv
// CU-side endpoint of the dispatcher wavefront protocol: slot allocation, launch
// descriptor FIFO toward the wavepool, and retire-to-done tag return.

module cu_wf_slot #(
  parameter int TAG_W = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  logic             dealloc,
  input  logic [TAG_W-1:0] tag_in,
  output logic             valid,
  output logic [TAG_W-1:0] tag
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
    end else if (alloc) begin
      valid <= 1'b1;
      tag   <= tag_in;
    end else if (dealloc) begin
      valid <= 1'b0;
    end
  end
endmodule

module cu_dispatch_receiver #(
  parameter int NUM_WF_SLOTS = 40,
  parameter int WF_ID_WIDTH  = 6,
  parameter int LAUNCH_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatch2cu_wf_dispatch,
  input  logic [3:0]             dispatch2cu_wg_wf_count,
  input  logic [5:0]             dispatch2cu_wf_size_dispatch,
  input  logic [8:0]             dispatch2cu_sgpr_base_dispatch,
  input  logic [9:0]             dispatch2cu_vgpr_base_dispatch,
  input  logic [14:0]            dispatch2cu_wf_tag_dispatch,
  input  logic [15:0]            dispatch2cu_lds_base_dispatch,
  input  logic [31:0]            dispatch2cu_start_pc_dispatch,
  output logic                   launch_valid,
  input  logic                   launch_ready,
  output logic [WF_ID_WIDTH-1:0] launch_wf_id,
  output logic [3:0]             launch_wg_wf_count,
  output logic [5:0]             launch_wf_size,
  output logic [8:0]             launch_sgpr_base,
  output logic [9:0]             launch_vgpr_base,
  output logic [15:0]            launch_lds_base,
  output logic [31:0]            launch_start_pc,
  input  logic                   retire_valid,
  input  logic [WF_ID_WIDTH-1:0] retire_wf_id,
  output logic                   cu2dispatch_wf_done,
  output logic [14:0]            cu2dispatch_wf_tag_done,
  output logic                   overflow_err,
  output logic                   retire_err
);
  localparam int PTR_W = (LAUNCH_DEPTH > 1) ? $clog2(LAUNCH_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [WF_ID_WIDTH-1:0] wf_id;
    logic [3:0]             wg_wf_count;
    logic [5:0]             wf_size;
    logic [8:0]             sgpr_base;
    logic [9:0]             vgpr_base;
    logic [15:0]            lds_base;
    logic [31:0]            start_pc;
  } launch_t;

  logic [NUM_WF_SLOTS-1:0]       slot_valid, slot_alloc, slot_dealloc, ret_sel;
  logic [NUM_WF_SLOTS-1:0][14:0] slot_tag;
  logic                          any_free, ret_hit, retire_ok, accept, pop, fifo_full;
  logic [WF_ID_WIDTH-1:0]        alloc_id;
  logic [14:0]                   ret_tag;
  logic [PTR_W-1:0]              wr_ptr, rd_ptr;
  logic [CNT_W-1:0]              count;
  launch_t                       fifo_mem [LAUNCH_DEPTH];
  launch_t                       push_ent, head;

  // Lowest-index free slot wins; slot_valid is registered, so a slot retired
  // this cycle only becomes allocatable next cycle.
  always_comb begin
    any_free = 1'b0;
    alloc_id = '0;
    for (int i = NUM_WF_SLOTS - 1; i >= 0; i--) begin
      if (!slot_valid[i]) begin
        any_free = 1'b1;
        alloc_id = WF_ID_WIDTH'(i);
      end
    end
  end

  // Decoding against every slot index makes out-of-range IDs miss naturally.
  always_comb begin
    ret_hit = 1'b0;
    ret_tag = '0;
    ret_sel = '0;
    for (int i = 0; i < NUM_WF_SLOTS; i++) begin
      if (retire_wf_id == WF_ID_WIDTH'(i)) begin
        ret_hit    = slot_valid[i];
        ret_tag    = slot_tag[i];
        ret_sel[i] = 1'b1;
      end
    end
  end

  assign launch_valid = (count != '0);
  assign fifo_full    = (count == CNT_W'(LAUNCH_DEPTH));
  assign pop          = launch_valid && launch_ready;
  assign accept       = dispatch2cu_wf_dispatch && any_free && (!fifo_full || pop) && !rst;
  assign retire_ok    = retire_valid && ret_hit && !rst;

  always_comb begin
    slot_alloc   = '0;
    slot_dealloc = '0;
    for (int i = 0; i < NUM_WF_SLOTS; i++) begin
      slot_alloc[i]   = accept && (alloc_id == WF_ID_WIDTH'(i));
      slot_dealloc[i] = retire_ok && ret_sel[i];
    end
  end

  for (genvar g = 0; g < NUM_WF_SLOTS; g++) begin : g_slot
    cu_wf_slot #(.TAG_W(15)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .alloc   (slot_alloc[g]),
      .dealloc (slot_dealloc[g]),
      .tag_in  (dispatch2cu_wf_tag_dispatch),
      .valid   (slot_valid[g]),
      .tag     (slot_tag[g])
    );
  end

  assign push_ent = '{
    wf_id:       alloc_id,
    wg_wf_count: dispatch2cu_wg_wf_count,
    wf_size:     dispatch2cu_wf_size_dispatch,
    sgpr_base:   dispatch2cu_sgpr_base_dispatch,
    vgpr_base:   dispatch2cu_vgpr_base_dispatch,
    lds_base:    dispatch2cu_lds_base_dispatch,
    start_pc:    dispatch2cu_start_pc_dispatch
  };

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= push_ent;
  end

  assign head               = launch_valid ? fifo_mem[rd_ptr] : '0;
  assign launch_wf_id       = head.wf_id;
  assign launch_wg_wf_count = head.wg_wf_count;
  assign launch_wf_size     = head.wf_size;
  assign launch_sgpr_base   = head.sgpr_base;
  assign launch_vgpr_base   = head.vgpr_base;
  assign launch_lds_base    = head.lds_base;
  assign launch_start_pc    = head.start_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      cu2dispatch_wf_done     <= 1'b0;
      cu2dispatch_wf_tag_done <= '0;
      overflow_err            <= 1'b0;
      retire_err              <= 1'b0;
    end else begin
      cu2dispatch_wf_done <= retire_ok;
      if (retire_ok) cu2dispatch_wf_tag_done <= ret_tag;
      if (dispatch2cu_wf_dispatch && !accept) overflow_err <= 1'b1;
      if (retire_valid && !ret_hit)           retire_err   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cu_dispatch_receiver.sv
// Bench for cu_dispatch_receiver: directed vector table, hand-written corner
// sequences and a randomized run against a queue/array reference model.

module tb_cu_dispatch_receiver;
  logic        clk = 1'b0;
  logic        rst;
  logic        d_disp;
  logic [3:0]  d_wg;
  logic [5:0]  d_size;
  logic [8:0]  d_sgpr;
  logic [9:0]  d_vgpr;
  logic [14:0] d_tag;
  logic [15:0] d_lds;
  logic [31:0] d_pc;
  logic        launch_valid, launch_ready;
  logic [5:0]  launch_wf_id;
  logic [3:0]  launch_wg_wf_count;
  logic [5:0]  launch_wf_size;
  logic [8:0]  launch_sgpr_base;
  logic [9:0]  launch_vgpr_base;
  logic [15:0] launch_lds_base;
  logic [31:0] launch_start_pc;
  logic        retire_valid;
  logic [5:0]  retire_wf_id;
  logic        wf_done;
  logic [14:0] wf_tag_done;
  logic        overflow_err, retire_err;

  always #5 clk = ~clk;

  cu_dispatch_receiver #(.NUM_WF_SLOTS(40), .WF_ID_WIDTH(6), .LAUNCH_DEPTH(4)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .dispatch2cu_wf_dispatch        (d_disp),
    .dispatch2cu_wg_wf_count        (d_wg),
    .dispatch2cu_wf_size_dispatch   (d_size),
    .dispatch2cu_sgpr_base_dispatch (d_sgpr),
    .dispatch2cu_vgpr_base_dispatch (d_vgpr),
    .dispatch2cu_wf_tag_dispatch    (d_tag),
    .dispatch2cu_lds_base_dispatch  (d_lds),
    .dispatch2cu_start_pc_dispatch  (d_pc),
    .launch_valid                   (launch_valid),
    .launch_ready                   (launch_ready),
    .launch_wf_id                   (launch_wf_id),
    .launch_wg_wf_count             (launch_wg_wf_count),
    .launch_wf_size                 (launch_wf_size),
    .launch_sgpr_base               (launch_sgpr_base),
    .launch_vgpr_base               (launch_vgpr_base),
    .launch_lds_base                (launch_lds_base),
    .launch_start_pc                (launch_start_pc),
    .retire_valid                   (retire_valid),
    .retire_wf_id                   (retire_wf_id),
    .cu2dispatch_wf_done            (wf_done),
    .cu2dispatch_wf_tag_done        (wf_tag_done),
    .overflow_err                   (overflow_err),
    .retire_err                     (retire_err)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: slot table as plain arrays, launch FIFO as a queue.
  typedef struct {
    logic [5:0]  id;
    logic [3:0]  wg;
    logic [5:0]  size;
    logic [8:0]  sgpr;
    logic [9:0]  vgpr;
    logic [15:0] lds;
    logic [31:0] pc;
  } ent_t;

  bit          m_used [40];
  logic [14:0] m_tag  [40];
  ent_t        m_q [$];
  bit          m_done, m_ovf, m_rerr;
  logic [14:0] m_tagdone;

  task automatic model_step();
    int  fr;
    bit  pop, acc, rok;
    ent_t e;
    if (rst) begin
      foreach (m_used[i]) m_used[i] = 0;
      m_q.delete();
      m_done = 0; m_ovf = 0; m_rerr = 0; m_tagdone = '0;
      return;
    end
    pop = (m_q.size() != 0) && launch_ready;
    fr = -1;
    for (int i = 0; i < 40; i++) if (!m_used[i] && fr < 0) fr = i;
    acc = d_disp && (fr >= 0) && (m_q.size() < 4 || pop);
    rok = retire_valid && (retire_wf_id < 40) && m_used[retire_wf_id];
    m_done = rok;
    if (rok) begin
      m_tagdone = m_tag[retire_wf_id];
      m_used[retire_wf_id] = 0;
    end
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      m_used[fr] = 1;
      m_tag[fr]  = d_tag;
      e = '{id: 6'(fr), wg: d_wg, size: d_size, sgpr: d_sgpr, vgpr: d_vgpr, lds: d_lds, pc: d_pc};
      m_q.push_back(e);
    end
    if (d_disp && !acc) m_ovf = 1;
    if (retire_valid && !rok) m_rerr = 1;
  endtask

  task automatic compare_model();
    ent_t e;
    e = '{default: '0};
    if (m_q.size() != 0) e = m_q[0];
    chk("launch_valid", 64'(launch_valid), 64'(m_q.size() != 0));
    chk("launch_wf_id", 64'(launch_wf_id), 64'(e.id));
    chk("launch_wg_wf_count", 64'(launch_wg_wf_count), 64'(e.wg));
    chk("launch_wf_size", 64'(launch_wf_size), 64'(e.size));
    chk("launch_sgpr_base", 64'(launch_sgpr_base), 64'(e.sgpr));
    chk("launch_vgpr_base", 64'(launch_vgpr_base), 64'(e.vgpr));
    chk("launch_lds_base", 64'(launch_lds_base), 64'(e.lds));
    chk("launch_start_pc", 64'(launch_start_pc), 64'(e.pc));
    chk("wf_done", 64'(wf_done), 64'(m_done));
    chk("wf_tag_done", 64'(wf_tag_done), 64'(m_tagdone));
    chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
    chk("retire_err", 64'(retire_err), 64'(m_rerr));
  endtask

  task automatic drv(bit r, bit d, int tag, int pc, int vg, bit rdy, bit rv, int rid);
    rst          = r;
    d_disp       = d;
    d_tag        = 15'(tag);
    d_pc         = 32'(pc);
    d_vgpr       = 10'(vg);
    d_wg         = 4'($urandom);
    d_size       = 6'($urandom);
    d_sgpr       = 9'($urandom);
    d_lds        = 16'($urandom);
    launch_ready = rdy;
    retire_valid = rv;
    retire_wf_id = 6'(rid);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  typedef struct {
    bit r, d; int tag, pc, vg; bit rdy, rv; int rid;
    bit ev; int eid, epc, evg; bit edone; int etag; bit eovf, erer;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1,0,0,0,0,0,0,0,              0,0,0,0,0,0,0,0};
    tbl[1]  = '{0,1,'h1234,'h100,8,0,0,0,     1,0,'h100,8,0,0,0,0};
    tbl[2]  = '{0,0,0,0,0,1,0,0,              0,0,0,0,0,0,0,0};
    tbl[3]  = '{1,0,0,0,0,0,0,0,              0,0,0,0,0,0,0,0};
    tbl[4]  = '{0,1,'h11,'h200,0,1,0,0,       1,0,'h200,0,0,0,0,0};
    tbl[5]  = '{0,1,'h22,'h204,0,1,0,0,       1,1,'h204,0,0,0,0,0};
    tbl[6]  = '{0,0,0,0,0,1,1,1,              0,0,0,0,1,'h22,0,0};
    tbl[7]  = '{0,1,'h33,'h300,0,0,0,0,       1,1,'h300,0,0,'h22,0,0};
    tbl[8]  = '{0,0,0,0,0,0,1,5,              1,1,'h300,0,0,'h22,0,1};
    tbl[9]  = '{0,0,0,0,0,0,1,45,             1,1,'h300,0,0,'h22,0,1};
    tbl[10] = '{0,0,0,0,0,0,1,0,              1,1,'h300,0,1,'h11,0,1};
    tbl[11] = '{0,0,0,0,0,0,0,0,              1,1,'h300,0,0,'h11,0,1};

    drv(1, 0, 0, 0, 0, 0, 0, 0);
    cyc();

    foreach (tbl[k]) begin
      drv(tbl[k].r, tbl[k].d, tbl[k].tag, tbl[k].pc, tbl[k].vg, tbl[k].rdy, tbl[k].rv, tbl[k].rid);
      cyc();
      chk($sformatf("tbl%0d.valid", k), 64'(launch_valid), 64'(tbl[k].ev));
      chk($sformatf("tbl%0d.wf_id", k), 64'(launch_wf_id), 64'(tbl[k].eid));
      chk($sformatf("tbl%0d.pc", k), 64'(launch_start_pc), 64'(32'(tbl[k].epc)));
      chk($sformatf("tbl%0d.vgpr", k), 64'(launch_vgpr_base), 64'(tbl[k].evg));
      chk($sformatf("tbl%0d.done", k), 64'(wf_done), 64'(tbl[k].edone));
      chk($sformatf("tbl%0d.tag", k), 64'(wf_tag_done), 64'(tbl[k].etag));
      chk($sformatf("tbl%0d.ovf", k), 64'(overflow_err), 64'(tbl[k].eovf));
      chk($sformatf("tbl%0d.rerr", k), 64'(retire_err), 64'(tbl[k].erer));
    end

    // Five back-to-back dispatches into a stalled FIFO: fifth is dropped.
    drv(1, 0, 0, 0, 0, 0, 0, 0); cyc();
    for (int i = 0; i < 5; i++) begin
      drv(0, 1, 'h40 + i, 'h1000 + 4 * i, i, 0, 0, 0);
      cyc();
      chk($sformatf("stall%0d.ovf", i), 64'(overflow_err), 64'(i == 4));
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d.wf_id", i), 64'(launch_wf_id), 64'(i));
      chk($sformatf("drain%0d.pc", i), 64'(launch_start_pc), 64'('h1000 + 4 * i));
      drv(0, 0, 0, 0, 0, 1, 0, 0);
      cyc();
    end
    chk("drain.empty", 64'(launch_valid), 64'(0));

    // Fill all 40 slots, then retire slot 0 in the same cycle as a dispatch.
    drv(1, 0, 0, 0, 0, 0, 0, 0); cyc();
    for (int i = 0; i < 40; i++) begin
      drv(0, 1, 'h100 + i, 'h2000 + i, 0, 1, 0, 0);
      cyc();
    end
    chk("full.ovf_before", 64'(overflow_err), 64'(0));
    drv(0, 1, 'h7777, 'h3000, 0, 0, 1, 0); cyc();
    chk("full.ovf", 64'(overflow_err), 64'(1));
    chk("full.done", 64'(wf_done), 64'(1));
    chk("full.tag", 64'(wf_tag_done), 64'('h100));
    drv(0, 0, 0, 0, 0, 0, 0, 0); cyc();
    chk("full.done_pulse", 64'(wf_done), 64'(0));

    // Full FIFO with ready held: push+pop every cycle, then reset mid-stream.
    drv(1, 0, 0, 0, 0, 0, 0, 0); cyc();
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 'h200 + i, 'h4000 + i, 0, 0, 0, 0); cyc();
    end
    for (int i = 1; i <= 6; i++) begin
      drv(0, 1, 'h300 + i, 'h5000 + i, 0, 1, 0, 0); cyc();
      chk($sformatf("stream%0d.head", i), 64'(launch_wf_id), 64'(i));
      chk($sformatf("stream%0d.ovf", i), 64'(overflow_err), 64'(0));
      chk($sformatf("stream%0d.valid", i), 64'(launch_valid), 64'(1));
    end
    drv(1, 1, 'h555, 'h6000, 0, 1, 1, 2); cyc();
    chk("rst.valid", 64'(launch_valid), 64'(0));
    chk("rst.pc", 64'(launch_start_pc), 64'(0));
    chk("rst.done", 64'(wf_done), 64'(0));
    chk("rst.errs", 64'({overflow_err, retire_err}), 64'(0));
    drv(0, 1, 'h666, 'h7000, 0, 0, 0, 0); cyc();
    chk("rst.reuse_slot0", 64'(launch_wf_id), 64'(0));
    chk("rst.reuse_valid", 64'(launch_valid), 64'(1));

    // Randomized run against the model.
    drv(1, 0, 0, 0, 0, 0, 0, 0); cyc();
    for (int n = 0; n < 3000; n++) begin
      int live [$];
      int rid;
      live.delete();
      for (int i = 0; i < 40; i++) if (m_used[i]) live.push_back(i);
      rid = int'($urandom_range(0, 47));
      if (live.size() != 0 && ($urandom % 4) != 0)
        rid = live[$urandom_range(0, live.size() - 1)];
      drv(($urandom % 250) == 0, ($urandom % 3) != 0, int'($urandom), int'($urandom),
          int'($urandom), $urandom % 2 == 0, ($urandom % 5) < 2, rid);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
